testbench_ls_pio_in_irq: RTL and testbench
==========================================

Name: testbench_ls_pio_in_irq

Overview:
Parametrised Avalon-MM slave for a general-purpose input port with per-bit edge capture, edge-type selection and interrupt generation. It is the next-generation input PIO for the testbench_ls system. It extends the fixed 8-bit rising-edge-only port with the following:
- configurable width and synchroniser depth
- per-bit rising/falling selection
- an IRQ mask and registered irq output
- a saturating edge-event counter

Parameters:
WIDTH, 8, input port width, 1..32
SYNC_STAGES, 2, synchroniser flops on in_port, minimum 2
CNT_W, 16, event counter width, 1..32
DEBOUNCE_CYCLES, 4, stable cycles required by the debounce filter (only with DEBOUNCE_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  level interrupt, active-high

Behaviour:
- Reset/clock: reset reset_n, asynchronous, active-low; clock clk. On reset every flop clears, so readdata=0, irq=0, edge_capture=0, irq_mask=0, rise_en=all-1, fall_en=0, counter=0, and all sync stages=0.
- Synchroniser: sync_in passes through a SYNC_STAGES flop chain to s, then one more flop to s_d. If in_port is high when reset releases, this produces a rising edge (intended).
- Edge detect: edge = (s & ~s_d & rise_en) | (~s & s_d & fall_en).
- Register map (reads return zero-extended values; unused bits read 0):
  - 0: data. RO. Returns s.
  - 2: irq_mask. RW.
  - 3: edge_capture. Write-1-to-clear per bit.
  - 4: rise_en. RW.
  - 5: fall_en. RW.
  - 6: event_cnt. RO. Any write clears it.
  - 1 and 7: read 0, writes ignored.
- Write: occurs when chipselect && !write_n. Only writedata[WIDTH-1:0] is used for registers 2-5.
- Read: readdata is registered every clock from the address mux, regardless of chipselect. Read latency is 1 clock.
- edge_capture[i]:
  - Set when edge[i] is asserted.
  - Cleared by a write to address 3 with writedata[i]=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- event_cnt:
  - Increments by 1 in any cycle where |edge is true, regardless of how many bits edged.
  - Saturates at 2^CNT_W-1.
  - If a write to address 6 coincides with an event, the counter becomes 1.
- irq: registered, irq <= |(edge_capture & irq_mask). It asserts 1 clock after the capture bit sets and deasserts 1 clock after the clear or mask.
- Latency: from the first clk edge that samples a new in_port level, edge_capture updates after SYNC_STAGES+1 clocks and irq after SYNC_STAGES+2 clocks.
- Changing rise_en/fall_en does not alter already-captured bits.

Optional Feature:
TESTBENCH_LS_PIO_DEBOUNCE_EN
- Defined: each synchronised bit passes through a per-bit debounce filter. The filter holds a counter of width clog2(DEBOUNCE_CYCLES+1) and a filtered output f[i] (reset 0).
  - When raw ≠ f[i], the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, f[i] takes raw and the counter clears.
  - When raw == f[i], the counter clears.
  - Edge detect, the data register and s use f. Latency increases by DEBOUNCE_CYCLES clocks.
- Undefined: no filter logic; s is the last sync stage.

Decomposition:
- Package testbench_ls_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3, ADDR_RISE=4, ADDR_FALL=5, ADDR_CNT=6
  - the reset value constants for rise_en/fall_en
- One sub-module: testbench_ls_pio_sync. It is a per-bit synchroniser plus the optional debounce filter, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES, and instantiated WIDTH times via generate.

Test Plan:
1. Reset release with in_port=8'h05 (defaults) -> edge_capture reads 8'h05 and event_cnt reads 1; irq stays 0 because mask=0.
2. Write mask=8'h01, then toggle in_port[0] 0->1 -> edge_capture[0]=1 after SYNC_STAGES+1 clocks and irq=1 one clock later. Writing 8'h01 to addr 3 drops irq 1 clock after the capture bit clears.
3. Write fall_en=8'h80 and rise_en=0, then in_port[7] 1->0 -> capture 8'h80; a subsequent 0->1 transition is not captured.
4. Write-1-clear to addr 3 in the same cycle as a new edge on bit 2 -> bit 2 remains 1.
5. CNT_W=4, drive 20 separate edges -> event_cnt saturates at 15. Writing addr 6 gives 0; writing while an edge occurs gives 1.
6. With TESTBENCH_LS_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
   - a 3-cycle pulse on in_port[1] -> no capture and data unchanged
   - a 6-cycle pulse -> captured, with latency SYNC_STAGES+1+4 clocks

Source files
------------

// File: rtl/testbench_ls_pio_pkg.sv
// Shared register map and reset constants for the testbench_ls input PIO.
package testbench_ls_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA = 3'd0,
    ADDR_MASK = 3'd2,
    ADDR_EDGE = 3'd3,
    ADDR_RISE = 3'd4,
    ADDR_FALL = 3'd5,
    ADDR_CNT  = 3'd6
  } reg_addr_e;

  // Sliced to WIDTH at the point of use.
  localparam logic [31:0] RISE_EN_RST = '1;
  localparam logic [31:0] FALL_EN_RST = '0;

endpackage

// File: rtl/testbench_ls_pio_sync.sv
// Single-bit input synchroniser with an optional stability filter.
// The filter is built only when TESTBENCH_LS_PIO_DEBOUNCE_EN is defined.
module testbench_ls_pio_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_bit,
  output logic sync_bit
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("testbench_ls_pio_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], async_bit};
  end

`ifdef TESTBENCH_LS_PIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          filt;

  assign cnt_inc = cnt + CW'(1);

  // Filtered level follows the synchronised bit only after it has differed
  // for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (chain[SYNC_STAGES-1] == filt) begin
      cnt <= '0;
    end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
      filt <= chain[SYNC_STAGES-1];
      cnt  <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  assign sync_bit = filt;
`else
  assign sync_bit = chain[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/testbench_ls_pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture, edge-type select, IRQ mask
// and saturating event counter. Optional filter: TESTBENCH_LS_PIO_DEBOUNCE_EN.
module testbench_ls_pio_in_irq
  import testbench_ls_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [CNT_W-1:0] event_cnt;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             any_edge;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    testbench_ls_pio_sync #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .async_bit (in_port[i]),
      .sync_bit  (s[i])
    );
  end

  assign wr_en    = chipselect & ~write_n;
  assign wdata    = writedata[WIDTH-1:0];
  assign edge_evt = (s & ~s_d & rise_en) | (~s & s_d & fall_en);
  assign any_edge = |edge_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_d      <= '0;
      irq_mask <= '0;
      rise_en  <= RISE_EN_RST[WIDTH-1:0];
      fall_en  <= FALL_EN_RST[WIDTH-1:0];
    end else begin
      s_d <= s;
      if (wr_en && address == ADDR_MASK) irq_mask <= wdata;
      if (wr_en && address == ADDR_RISE) rise_en  <= wdata;
      if (wr_en && address == ADDR_FALL) fall_en  <= wdata;
    end
  end

  // New edges are OR-ed in after the W1C so a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_en && address == ADDR_EDGE) begin
      edge_capture <= (edge_capture & ~wdata) | edge_evt;
    end else begin
      edge_capture <= edge_capture | edge_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_cnt <= '0;
    end else if (wr_en && address == ADDR_CNT) begin
      event_cnt <= any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && event_cnt != '1) begin
      event_cnt <= event_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd_next = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: rd_next[WIDTH-1:0] = s;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
      ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
      ADDR_CNT:  rd_next[CNT_W-1:0] = event_cnt;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_testbench_ls_pio_in_irq.sv
// Directed, table-driven bench for testbench_ls_pio_in_irq (WIDTH=8, CNT_W=4).
module tb_testbench_ls_pio_in_irq;

  localparam int unsigned SYNC = 2;
`ifdef TESTBENCH_LS_PIO_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 0;
`endif
  localparam int unsigned LAT = SYNC + 1 + DB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  testbench_ls_pio_in_irq #(
    .WIDTH           (8),
    .SYNC_STAGES     (SYNC),
    .CNT_W           (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    bit          do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
  endtask

  // Drive a new input level and land a write exactly on the capturing edge.
  task automatic edge_with_write(input logic [7:0] new_in, input logic [2:0] a,
                                 input logic [31:0] d);
    @(negedge clk);
    in_port = new_in;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    vecs[0]  = '{3'd4, 1'b0, 32'h0,        32'hff};
    vecs[1]  = '{3'd5, 1'b0, 32'h0,        32'h00};
    vecs[2]  = '{3'd2, 1'b0, 32'h0,        32'h00};
    vecs[3]  = '{3'd0, 1'b0, 32'h0,        32'h05};
    vecs[4]  = '{3'd1, 1'b1, 32'hffffffff, 32'h00};
    vecs[5]  = '{3'd7, 1'b1, 32'hffffffff, 32'h00};
    vecs[6]  = '{3'd2, 1'b1, 32'h000001a5, 32'ha5};
    vecs[7]  = '{3'd2, 1'b1, 32'h0,        32'h00};
    vecs[8]  = '{3'd5, 1'b1, 32'h3c,       32'h3c};
    vecs[9]  = '{3'd5, 1'b1, 32'h0,        32'h00};
    vecs[10] = '{3'd3, 1'b1, 32'h04,       32'h01};
    vecs[11] = '{3'd3, 1'b1, 32'hff,       32'h00};
    vecs[12] = '{3'd6, 1'b0, 32'h0,        32'h01};
    vecs[13] = '{3'd6, 1'b1, 32'h0,        32'h00};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'h05;
    idle(3); #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // 1: inputs high at reset release appear as rising edges
    idle(10 + DB);
    rd(3'd3, v); check("t1_edge_capture", v, 32'h05);
    rd(3'd6, v); check("t1_event_cnt", v, 32'h01);
    check("t1_irq_masked", {31'h0, irq}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, v);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), v, vecs[i].exp);
    end

    // 2: latency of capture and irq, then W1C drops irq
    wr(3'd2, 32'h01);
    @(negedge clk); in_port = 8'h04;
    idle(12 + DB);
    wr(3'd3, 32'hff);
    @(negedge clk); in_port = 8'h05; address = 3'd3;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      @(posedge clk); #1;
      if (k == int'(LAT)) begin
        check("t2_capture_not_yet", readdata, 32'h0);
        check("t2_irq_not_yet", {31'h0, irq}, 32'h0);
      end
      if (k == int'(LAT) + 1) begin
        check("t2_capture_set", readdata, 32'h01);
        check("t2_irq_set", {31'h0, irq}, 32'h1);
      end
    end
    wr(3'd3, 32'h01);
    check("t2_irq_after_clear_edge", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    check("t2_irq_dropped", {31'h0, irq}, 32'h0);
    rd(3'd3, v); check("t2_capture_cleared", v, 32'h0);
    wr(3'd2, 32'h0);

    // 3: falling-only on bit 7
    wr(3'd5, 32'h80); wr(3'd4, 32'h0);
    @(negedge clk); in_port = 8'h85;
    idle(10 + DB);
    rd(3'd3, v); check("t3_rise_ignored", v, 32'h0);
    @(negedge clk); in_port = 8'h05;
    idle(10 + DB);
    rd(3'd3, v); check("t3_fall_captured", v, 32'h80);
    wr(3'd3, 32'h80);
    @(negedge clk); in_port = 8'h85;
    idle(10 + DB);
    rd(3'd3, v); check("t3_rise_again_ignored", v, 32'h0);
    wr(3'd4, 32'hff); wr(3'd5, 32'h0);
    @(negedge clk); in_port = 8'h05;
    idle(10 + DB);
    wr(3'd3, 32'hff);

    // 4: set wins over coincident W1C on bit 2
    @(negedge clk); in_port = 8'h01;
    idle(10 + DB);
    wr(3'd3, 32'hff);
    edge_with_write(8'h05, 3'd3, 32'h04);
    rd(3'd3, v); check("t4_set_wins", v, 32'h04);
    wr(3'd3, 32'h04);
    rd(3'd3, v); check("t4_later_clear", v, 32'h0);

    // 5: counter saturation and clear
    wr(3'd6, 32'h0);
    rd(3'd6, v); check("t5_cnt_cleared", v, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); in_port = 8'h0d;
      idle(LAT + 2);
      @(negedge clk); in_port = 8'h05;
      idle(LAT + 2);
      if (n == 14) begin
        rd(3'd6, v); check("t5_cnt_14", v, 32'd14);
      end
    end
    rd(3'd6, v); check("t5_cnt_saturated", v, 32'd15);
    wr(3'd6, 32'h0);
    rd(3'd6, v); check("t5_cnt_write_clear", v, 32'h0);
    edge_with_write(8'h0d, 3'd6, 32'h0);
    rd(3'd6, v); check("t5_cnt_write_with_edge", v, 32'h1);
    @(negedge clk); in_port = 8'h05;
    idle(LAT + 2);
    wr(3'd3, 32'hff);

`ifdef TESTBENCH_LS_PIO_DEBOUNCE_EN
    // 6: short pulse rejected, long pulse captured with extra latency
    @(negedge clk); in_port = 8'h07;
    idle(3);
    @(negedge clk); in_port = 8'h05;
    idle(15);
    rd(3'd3, v); check("t6_short_pulse_edge", v, 32'h0);
    rd(3'd0, v); check("t6_short_pulse_data", v, 32'h05);
    @(negedge clk); in_port = 8'h07; address = 3'd3;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      @(posedge clk); #1;
      if (k == 6) in_port = 8'h05;
      if (k == int'(LAT)) check("t6_long_not_yet", readdata, 32'h0);
      if (k == int'(LAT) + 1) check("t6_long_captured", readdata, 32'h02);
    end
    idle(15);
    wr(3'd3, 32'hff);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
